// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, done pulses
// for one cycle once WIDTH partial products have been accumulated.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  assign done    = busy_q && (cnt_q == CW'(WIDTH));
  assign product = acc_q;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q && !done) begin
      // Multiplier LSB selects whether the current shifted multiplicand is added.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end else if (done) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops, multi-cycle
// multiply, and a registered result/flag stage that holds under backpressure.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int SW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res_y;
  logic               res_c, res_v;
  op_e                op;

  assign op        = op_e'(sel);
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !rst;
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign c         = c_q;
  assign z         = z_q;
  assign v         = v_q;
  assign n         = n_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD: begin
        res_y = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Extended-width subtract: the top bit is the unsigned borrow.
        res_y = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_y = a & b;
      OP_OR:   res_y = a | b;
      OP_XOR:  res_y = a ^ b;
      OP_NOT:  res_y = ~a;
      OP_SHL:  res_y = a << b[SW-1:0];
      OP_MUL:  res_y = '0;
      default: res_y = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    c_d       = c_q;
    z_d       = z_q;
    v_d       = v_q;
    n_d       = n_q;
    mul_start = 1'b0;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            y_d         = res_y;
            c_d         = res_c;
            v_d         = res_v;
            z_d         = (res_y == '0);
            n_d         = res_y[WIDTH-1];
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          y_d         = mul_product[WIDTH-1:0];
          c_d         = |mul_product[2*WIDTH-1:WIDTH];
          v_d         = 1'b0;
          z_d         = (mul_product[WIDTH-1:0] == '0);
          n_d         = mul_product[WIDTH-1];
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      c_q         <= c_d;
      z_q         <= z_d;
      v_q         <= v_d;
      n_q         <= n_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus random bench for alu_seq (WIDTH=4) with an expected-result queue.
module tb_alu_seq;

  typedef struct packed {
    logic [3:0] y;
    logic       c;
    logic       z;
    logic       v;
    logic       n;
  } res_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] a, b, y;
  logic [2:0] sel;
  logic       c, z, v, n;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];

  alu_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .c         (c),
    .z         (z),
    .v         (v),
    .n         (n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  function automatic res_t mk(input logic [3:0] ry, input logic rc, input logic rv);
    res_t r;
    r.y = ry;
    r.c = rc;
    r.z = (ry == 4'd0);
    r.v = rv;
    r.n = ry[3];
    return r;
  endfunction

  // Independent reference built from integer arithmetic.
  function automatic res_t model(input logic [2:0] op, input logic [3:0] ma, input logic [3:0] mb);
    int   ua, ub, sa, sb, full;
    logic rc, rv;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    rc = 1'b0;
    rv = 1'b0;
    case (op)
      3'd0: begin full = ua + ub; rc = (full > 15); rv = ((sa + sb) > 7) || ((sa + sb) < -8); end
      3'd1: begin full = ua - ub + 16; rc = (ua < ub); rv = ((sa - sb) > 7) || ((sa - sb) < -8); end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: full = 15 - ua;
      3'd6: full = ua << (ub % 4);
      3'd7: begin full = ua * ub; rc = (full > 15); end
      default: full = 0;
    endcase
    return mk(4'(full % 16), rc, rv);
  endfunction

  task automatic issue(input logic [2:0] op, input logic [3:0] ia, input logic [3:0] ib, input res_t e);
    int k;
    sel      = op;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      next();
      #1;
      k++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    exp_q.push_back(e);
    next();
    in_valid = 1'b0;
  endtask

  // Scoreboard: each result consumed by the handshake is popped and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'({y, c, z, v, n}), 32'hFFFF_FFFF);
      end else begin
        chk("result", 32'({y, c, z, v, n}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [2:0] rop;
    logic [3:0] ra, rb;
    int         k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 4'd0;
    b         = 4'd0;
    sel       = 3'd0;
    next();
    next();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'({c, z, v, n}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    next();

    issue(3'd0, 4'd9, 4'd8, mk(4'd1, 1'b1, 1'b1));
    #1;
    chk("add_latency", 32'(out_valid), 32'd1);
    issue(3'd1, 4'd3, 4'd5, mk(4'd14, 1'b1, 1'b0));

    issue(3'd7, 4'd7, 4'd5, mk(4'd3, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mul_in_ready_low", 32'(in_ready), 32'd0);
      chk("mul_out_valid_low", 32'(out_valid), 32'd0);
      next();
    end
    #1;
    chk("mul_out_valid_rise", 32'(out_valid), 32'd1);
    chk("mul_in_ready_back", 32'(in_ready), 32'd1);
    next();

    out_ready = 1'b0;
    issue(3'd0, 4'd1, 4'd1, mk(4'd2, 1'b0, 1'b0));
    in_valid = 1'b1;
    sel      = 3'd0;
    a        = 4'd5;
    b        = 4'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_y", 32'(y), 32'd2);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      next();
    end
    out_ready = 1'b1;
    issue(3'd6, 4'd3, 4'd5, mk(4'd6, 1'b0, 1'b0));
    next();

    issue(3'd7, 4'd15, 4'd15, mk(4'd1, 1'b1, 1'b0));
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      next();
      #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    next();
    issue(3'd0, 4'd0, 4'd0, mk(4'd0, 1'b0, 1'b0));
    #1;
    chk("zero_flag", 32'(z), 32'd1);
    next();

    issue(3'd2, 4'd12, 4'd10, mk(4'd8, 1'b0, 1'b0));
    #1;
    chk("b2b_and", 32'(y), 32'd8);
    issue(3'd3, 4'd12, 4'd10, mk(4'd14, 1'b0, 1'b0));
    #1;
    chk("b2b_or", 32'(y), 32'd14);
    issue(3'd4, 4'd12, 4'd10, mk(4'd6, 1'b0, 1'b0));
    #1;
    chk("b2b_xor", 32'(y), 32'd6);
    next();

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      issue(rop, ra, rb, model(rop, ra, rb));
      if ($urandom_range(0, 3) == 0) next();
    end

    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      next();
      k++;
    end
    next();
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width; legal values 4, 8, 16, 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block accepts the request this cycle.
REQ-006 a, b  input  WIDTH each  operands, unsigned unless stated.
REQ-007 sel  input  3  opcode.
REQ-008 out_valid  output  1  result register holds an unconsumed result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 y  output  WIDTH  result.
REQ-011 c, z, v, n  output  1 each  carry/borrow, zero, signed overflow, negative (y MSB).

Function
REQ-012 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL, 111 MUL.
REQ-013 Request accepted on an edge where in_valid && in_ready; a, b and sel are sampled only then.
REQ-014 in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst.
REQ-015 FSM states IDLE, MUL; IDLE -> MUL on accepted MUL; MUL -> IDLE when iteration count reaches WIDTH; all other opcodes stay in IDLE.
REQ-016 Non-MUL ops: y and flags registered on the accepting edge; out_valid high from the following cycle (latency 1).
REQ-017 MUL: unsigned shift-add, one partial product per cycle; out_valid rises exactly WIDTH+1 cycles after acceptance; in_ready low throughout.
REQ-018 ADD: y = (a+b) mod 2^WIDTH; c = carry out; v = two's-complement overflow.
REQ-019 SUB: y = (a-b) mod 2^WIDTH; c = 1 when a < b unsigned (borrow); v = two's-complement overflow.
REQ-020 SHL: y = a << (b mod WIDTH), zero fill; c = 0; v = 0.
REQ-021 MUL: y = low WIDTH bits of a*b; c = 1 when any high-half product bit is nonzero; v = 0.
REQ-022 Logic ops (AND, OR, XOR, NOT): c = 0, v = 0.
REQ-023 All ops: z = (y == 0); n = y[WIDTH-1].
REQ-024 Result register and flags hold stable while out_valid && !out_ready.
REQ-025 out_valid clears on an edge with out_ready high unless a new result loads on the same edge (back-to-back non-MUL ops at one per cycle).
REQ-026 in_valid while in_ready is low: ignored, no state change.

Reset
REQ-027 While rst high at an edge: state <= IDLE, out_valid <= 0, y <= 0, c/z/v/n <= 0, MUL counter and accumulator cleared.
REQ-028 rst during MUL aborts the operation; no result is ever presented for it.
REQ-029 in_ready is low while rst is high and goes high in the first cycle after rst deasserts.

Structure
REQ-030 Shared package alu_pkg holds opcode constants and the FSM state encoding.
REQ-031 Multiplier is a sub-module alu_mul_seq (start, a, b, done, product[2*WIDTH-1:0]) with the same clk/rst.
REQ-032 Result/flag register and handshake logic live in alu_seq; no latches; no combinational path from out_ready to y.

Verification (WIDTH=4)
REQ-033 ADD a=9, b=8 -> next cycle out_valid=1, y=1, c=1, v=1, z=0, n=0.
REQ-034 SUB a=3, b=5 -> y=14, c=1, n=1, v=0, z=0.
REQ-035 MUL a=7, b=5 -> in_ready low 5 cycles, out_valid rises 5 cycles after accept, y=3, c=1.
REQ-036 out_ready=0, ADD 1+1 -> y=2 held, in_ready=0 until out_ready pulses; then accept SHL a=3, b=5 -> y=6, c=0.
REQ-037 Accept MUL 15*15, assert rst 2 cycles later for one cycle -> out_valid stays 0, in_ready=1 the cycle after; ADD 0+0 -> y=0, z=1.
REQ-038 Back-to-back AND 12&10, OR 12|10, XOR 12^10 with out_ready=1 -> one result per cycle: 8, 14, 6.
